// File: rtl/rms_ctrl_pkg.sv
// Shared encodings for the register/memory-stage control FSM: opcodes, states,
// mux select codes and the bundled control word.
package rms_ctrl_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_LI   = 4'h4;
  localparam logic [3:0] OP_LW   = 4'h5;
  localparam logic [3:0] OP_SW   = 4'h6;
  localparam logic [3:0] OP_MOV  = 4'h7;
  localparam logic [3:0] OP_SLT  = 4'h8;
  localparam logic [3:0] OP_BEQ  = 4'h9;
  localparam logic [3:0] OP_BNE  = 4'hA;
  localparam logic [3:0] OP_J    = 4'hB;
  localparam logic [3:0] OP_JAL  = 4'hC;
  localparam logic [3:0] OP_RET  = 4'hD;
  localparam logic [3:0] OP_NOP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_IMM    = 4'd2,
    S_READ   = 4'd3,
    S_EXEC   = 4'd4,
    S_MEM    = 4'd5,
    S_WB     = 4'd6,
    S_JUMP   = 4'd7,
    S_HALT   = 4'd8
  } state_t;

  localparam logic [1:0] PC_INC    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_IMR    = 2'b10;
  localparam logic [1:0] PC_REGA   = 2'b11;

  localparam logic [1:0] RS_IMR  = 2'b00;
  localparam logic [1:0] RS_ALU  = 2'b01;
  localparam logic [1:0] RS_MEM  = 2'b10;
  localparam logic [1:0] RS_REGA = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef struct packed {
    logic       memReq;
    logic       memWe;
    logic       memSel;
    logic       irWrite;
    logic       imrWrite;
    logic       pcWrite;
    logic [1:0] pcSrc;
    logic [1:0] aluOp;
    logic       regR1;
    logic       regR2;
    logic       regW1;
    logic       regW2;
    logic       writeCr;
    logic       restore;
    logic       cmpEq;
    logic       cmpNe;
    logic [1:0] regSrc;
    logic       saveFc;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/rms_ctrl_decode.sv
// Combinational control-word decode from the current state and latched opcode;
// only the memory-completion and branch-taken strobes look at live inputs.
module rms_ctrl_decode
  import rms_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] opQ,
  input  logic       cmpResult,
  input  logic       memReady,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.memReq = 1'b1;
        if (memReady) begin
          ctrl.irWrite = 1'b1;
          ctrl.pcWrite = 1'b1;
          ctrl.pcSrc   = PC_INC;
        end
      end
      S_IMM: begin
        ctrl.memReq = 1'b1;
        if (memReady) begin
          ctrl.imrWrite = 1'b1;
          ctrl.pcWrite  = 1'b1;
          ctrl.pcSrc    = PC_INC;
        end
      end
      S_READ: begin
        ctrl.regR1 = 1'b1;
        ctrl.regR2 = 1'b1;
      end
      S_EXEC: begin
        case (opQ)
          OP_ADD, OP_SUB, OP_AND, OP_OR: ctrl.aluOp = opQ[1:0];
          OP_SLT: begin
            // AltB lands in the condition register through write port 1
            ctrl.aluOp   = ALU_SUB;
            ctrl.regW1   = 1'b1;
            ctrl.writeCr = 1'b1;
          end
          OP_BEQ, OP_BNE: begin
            ctrl.cmpEq = (opQ == OP_BEQ);
            ctrl.cmpNe = (opQ == OP_BNE);
            if (cmpResult) begin
              ctrl.pcWrite = 1'b1;
              ctrl.pcSrc   = PC_BRANCH;
            end
          end
          OP_LW, OP_SW: ctrl.aluOp = ALU_ADD;
          OP_RET: begin
            ctrl.restore = 1'b1;
            ctrl.pcWrite = 1'b1;
            ctrl.pcSrc   = PC_REGA;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        ctrl.memReq = 1'b1;
        ctrl.memSel = 1'b1;
        ctrl.memWe  = (opQ == OP_SW);
      end
      S_WB: begin
        ctrl.regW2 = 1'b1;
        case (opQ)
          OP_LI:   ctrl.regSrc = RS_IMR;
          OP_LW:   ctrl.regSrc = RS_MEM;
          OP_MOV:  ctrl.regSrc = RS_REGA;
          default: ctrl.regSrc = RS_ALU;
        endcase
      end
      S_JUMP: begin
        ctrl.pcWrite = 1'b1;
        ctrl.pcSrc   = PC_IMR;
        ctrl.saveFc  = (opQ == OP_JAL);
      end
      S_HALT: ctrl.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/rms_control.sv
// Multicycle control FSM for the register/memory stage and its req/ready memory
// port: state and opcode registers, next-state logic, and reset-gated outputs.
module rms_control
  import rms_ctrl_pkg::*;
#(
  parameter int OP_W    = 4,
  parameter int CR_ADDR = 57
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OP_W-1:0] op,
  input  logic            cmp_result,
  input  logic            mem_ready,
  output logic            mem_req,
  output logic            mem_we,
  output logic            mem_sel,
  output logic            IRWrite,
  output logic            ImRWrite,
  output logic            PCWrite,
  output logic [1:0]      PCsrc,
  output logic [1:0]      ALUop,
  output logic            RegR1,
  output logic            RegR2,
  output logic            RegW1,
  output logic            RegW2,
  output logic            writeCR,
  output logic            restore,
  output logic            cmpeq,
  output logic            cmpne,
  output logic [1:0]      Regsrc,
  output logic            save_fc,
  output logic            halted,
  output logic [3:0]      state
);

  // The CR index lives in the datapath; it is only sanity-checked here.
  if (OP_W != 4 || CR_ADDR < 0) begin : gBadParams
    $error("rms_control: OP_W must be 4 and CR_ADDR non-negative");
  end

  state_t          stateQ;
  state_t          stateNext;
  logic [OP_W-1:0] opQ;
  ctrl_t           dec;
  ctrl_t           ctrl;

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ <= S_FETCH;
      opQ    <= '0;
    end else begin
      stateQ <= stateNext;
      if (stateQ == S_DECODE) opQ <= op;
    end
  end

  always_comb begin
    stateNext = S_FETCH;
    case (stateQ)
      S_FETCH: stateNext = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LI, OP_J, OP_JAL: stateNext = S_IMM;
          OP_HALT:             stateNext = S_HALT;
          OP_NOP:              stateNext = S_FETCH;
          default:             stateNext = S_READ;
        endcase
      end
      S_IMM: begin
        if (!mem_ready)        stateNext = S_IMM;
        else if (opQ == OP_LI) stateNext = S_WB;
        else                   stateNext = S_JUMP;
      end
      S_READ: stateNext = S_EXEC;
      S_EXEC: begin
        case (opQ)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MOV: stateNext = S_WB;
          OP_LW, OP_SW:                          stateNext = S_MEM;
          default:                               stateNext = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (!mem_ready)        stateNext = S_MEM;
        else if (opQ == OP_LW) stateNext = S_WB;
        else                   stateNext = S_FETCH;
      end
      S_HALT:  stateNext = S_HALT;
      default: stateNext = S_FETCH;
    endcase
  end

  rms_ctrl_decode uDecode (
    .state     (stateQ),
    .opQ       (opQ),
    .cmpResult (cmp_result),
    .memReady  (mem_ready),
    .ctrl      (dec)
  );

  // Reset gates every output combinationally so an in-flight request drops at once.
  always_comb begin
    ctrl  = reset ? '0 : dec;
    state = reset ? 4'd0 : stateQ;
  end

  assign mem_req  = ctrl.memReq;
  assign mem_we   = ctrl.memWe;
  assign mem_sel  = ctrl.memSel;
  assign IRWrite  = ctrl.irWrite;
  assign ImRWrite = ctrl.imrWrite;
  assign PCWrite  = ctrl.pcWrite;
  assign PCsrc    = ctrl.pcSrc;
  assign ALUop    = ctrl.aluOp;
  assign RegR1    = ctrl.regR1;
  assign RegR2    = ctrl.regR2;
  assign RegW1    = ctrl.regW1;
  assign RegW2    = ctrl.regW2;
  assign writeCR  = ctrl.writeCr;
  assign restore  = ctrl.restore;
  assign cmpeq    = ctrl.cmpEq;
  assign cmpne    = ctrl.cmpNe;
  assign Regsrc   = ctrl.regSrc;
  assign save_fc  = ctrl.saveFc;
  assign halted   = ctrl.halted;

endmodule
